// File: rtl/bitty_fetch_unit.sv
// Instruction fetch/sequencing stage in front of the Bitty core.
// Holds the PC, reads instructions from synchronous memory, and resolves
// branches and halt locally. Only ALU instructions are handed to the core.
// Optional breakpoint logic: define BITTY_FETCH_BREAKPOINT_EN.
module bitty_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              cpu_done,
  input  logic [DATA_W-1:0] cpu_d_out,
  output logic [DATA_W-1:0] d_instr,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
`ifdef BITTY_FETCH_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit,
`endif
  output logic              halted
);

  localparam logic [DATA_W-1:0] HALT_INSTR = {DATA_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    DECODE,
    EXEC,
    WAIT_DONE,
    HALT
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] instr, instr_d;
  logic [DATA_W-1:0] d_instr_d;
  logic              branch_taken;
`ifdef BITTY_FETCH_BREAKPOINT_EN
  logic              bp_hit_d;
`endif

  // The memory address is always the current PC.
  assign mem_addr = pc;

  // Next-state, next-PC and instruction latching.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    instr_d      = instr;
    d_instr_d    = d_instr;
    branch_taken = 1'b0;
`ifdef BITTY_FETCH_BREAKPOINT_EN
    bp_hit_d     = bp_hit;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT_MEM;
      WAIT_MEM: begin
        instr_d = mem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        if (instr == HALT_INSTR) begin
          state_d = HALT;
        end else if (instr[1:0] == 2'b10) begin
          case (instr[3:2])
            2'b00:   branch_taken = (cpu_d_out == DATA_W'(0));
            2'b01:   branch_taken = (cpu_d_out == DATA_W'(1));
            2'b10:   branch_taken = (cpu_d_out == DATA_W'(2));
            default: branch_taken = 1'b1;
          endcase
          pc_d    = branch_taken ? instr[ADDR_W+3:4] : pc + ADDR_W'(1);
          state_d = FETCH;
        end else begin
          d_instr_d = instr;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (cpu_done) begin
          pc_d    = pc + ADDR_W'(1);
          state_d = FETCH;
        end
      end
      HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BITTY_FETCH_BREAKPOINT_EN
    // A restart clears the hit flag; a fetch landing on bp_addr halts instead of reading.
    if (start && (state == IDLE || state == HALT)) begin
      bp_hit_d = 1'b0;
    end
    if (state_d == FETCH && bp_en && pc_d == bp_addr) begin
      state_d  = HALT;
      bp_hit_d = 1'b1;
    end
`endif
  end

  // State, PC and registered outputs; reset also drops run immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= '0;
      instr     <= '0;
      d_instr   <= '0;
      run       <= 1'b0;
      mem_rd_en <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      instr     <= instr_d;
      d_instr   <= d_instr_d;
      run       <= (state_d == EXEC);
      mem_rd_en <= (state_d == FETCH);
      halted    <= (state_d == HALT);
    end
  end

`ifdef BITTY_FETCH_BREAKPOINT_EN
  // Breakpoint hit flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_hit <= 1'b0;
    end else begin
      bp_hit <= bp_hit_d;
    end
  end
`endif

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Directed bench for bitty_fetch_unit with a synchronous memory and a simple core model.
module tb_bitty_fetch_unit;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_d_out;
  logic [DATA_W-1:0] d_instr;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              halted;
`ifdef BITTY_FETCH_BREAKPOINT_EN
  logic              bp_en = 1'b0;
  logic [ADDR_W-1:0] bp_addr = '0;
  logic              bp_hit;
`endif

  int checks = 0;
  int errors = 0;

  bitty_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .cpu_done  (cpu_done),
    .cpu_d_out (cpu_d_out),
    .d_instr   (d_instr),
    .run       (run),
    .pc        (pc),
`ifdef BITTY_FETCH_BREAKPOINT_EN
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .bp_hit    (bp_hit),
`endif
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory.
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // Core model: done pulses 5 cycles after run; reset by the same net.
  int          core_cnt;
  logic        core_done;
  logic        done_force = 1'b0;
  logic [15:0] core_dout = '0;
  assign cpu_done  = core_done | done_force;
  assign cpu_d_out = core_dout;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      core_done <= 1'b0;
      if (run) core_cnt <= 5;
      else if (core_cnt != 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) core_done <= 1'b1;
      end
    end
  end

  // Monitors: run pulses, instruction held until done, reads of address 2.
  int          run_cnt = 0;
  int          held_bad = 0;
  int          rd2 = 0;
  logic [15:0] run_log [16];
  logic [15:0] held_val = '0;
  always @(posedge clk) begin
    if (run) begin
      run_log[run_cnt[3:0]] = d_instr;
      held_val = d_instr;
      run_cnt++;
    end
    if (core_done && d_instr !== held_val) held_bad++;
    if (mem_rd_en && mem_addr == 8'd2) rd2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    check("halt_wait", 32'(halted), 32'd1);
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (!run && n < budget) begin @(negedge clk); n++; end
    check("run_wait", 32'(run), 32'd1);
  endtask

  task automatic wait_rd(input int budget);
    int n = 0;
    while (!mem_rd_en && n < budget) begin @(negedge clk); n++; end
    check("rd_wait", 32'(mem_rd_en), 32'd1);
  endtask

  logic [15:0] br_instr [5] = '{16'h0106, 16'h0106, 16'h020A, 16'h0302, 16'h0302};
  logic [15:0] br_dout  [5] = '{16'd1,    16'd2,    16'd2,    16'd0,    16'd1};
  logic [7:0]  br_pc    [5] = '{8'h10,    8'h02,    8'h20,    8'h30,    8'h02};

  initial begin
    int r0;
    int h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({run, mem_rd_en, halted}), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_dinstr", 32'(d_instr), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle", 32'({run, mem_rd_en, halted, pc}), 32'd0);
    end

    // Straight-line program
    mem[0] = 16'h1230; mem[1] = 16'h4561; mem[2] = 16'h7893; mem[3] = 16'hFFFF;
    r0 = run_cnt; h0 = held_bad;
    pulse_start();
    check("fetch_rd", 32'(mem_rd_en), 32'd1);
    check("fetch_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("fetch_one_cycle", 32'(mem_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    check("run_latency", 32'(run), 32'd1);
    check("run_instr", 32'(d_instr), 32'h1230);
    @(negedge clk);
    check("run_pulse", 32'(run), 32'd0);
    wait_halt(300);
    check("sl_runs", 32'(run_cnt - r0), 32'd3);
    check("sl_i0", 32'(run_log[4'(r0)]), 32'h1230);
    check("sl_i1", 32'(run_log[4'(r0 + 1)]), 32'h4561);
    check("sl_i2", 32'(run_log[4'(r0 + 2)]), 32'h7893);
    check("sl_held", 32'(held_bad - h0), 32'd0);
    check("sl_pc", 32'(pc), 32'd3);

    // Conditional branches
    mem[0] = 16'h0120; mem[2] = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      mem[1] = br_instr[i];
      core_dout = br_dout[i];
      r0 = run_cnt;
      @(negedge clk);
      pulse_start();
      wait_halt(200);
      check("br_pc", 32'(pc), 32'(br_pc[i]));
      check("br_runs", 32'(run_cnt - r0), 32'd1);
    end

    // PC wrap via unconditional branch to 0xFF
    mem[0] = 16'h0FFE; mem[8'hFF] = 16'h5550;
    r0 = run_cnt;
    @(negedge clk);
    pulse_start();
    wait_run(100);
    check("wrap_instr", 32'(d_instr), 32'h5550);
    check("wrap_pc_ff", 32'(pc), 32'hFF);
    wait_rd(100);
    check("wrap_addr", 32'(mem_addr), 32'd0);
    check("wrap_runs", 32'(run_cnt - r0), 32'd1);

    // Reset while waiting for done; late done ignored
    wait_run(100);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_run", 32'(run), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_ctrl", 32'({mem_rd_en, halted}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    done_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("late_done", 32'({run, mem_rd_en, halted, pc}), 32'd0);
    end
    done_force = 1'b0;
    mem[0] = 16'h1110; mem[1] = 16'h2220; mem[2] = 16'h3330; mem[3] = 16'hFFFF;
    r0 = run_cnt;
    @(negedge clk);
    pulse_start();
    check("restart_rd", 32'(mem_rd_en), 32'd1);
    check("restart_addr", 32'(mem_addr), 32'd0);
    wait_halt(300);
    check("restart_pc", 32'(pc), 32'd3);
    check("restart_runs", 32'(run_cnt - r0), 32'd3);

`ifdef BITTY_FETCH_BREAKPOINT_EN
    // Breakpoint at address 2
    bp_en = 1'b1; bp_addr = 8'd2;
    r0 = run_cnt; h0 = rd2;
    @(negedge clk);
    pulse_start();
    wait_halt(300);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_pc", 32'(pc), 32'd2);
    check("bp_runs", 32'(run_cnt - r0), 32'd2);
    check("bp_no_read", 32'(rd2 - h0), 32'd0);
    bp_en = 1'b0;
    @(negedge clk);
    pulse_start();
    check("bp_clear", 32'(bp_hit), 32'd0);
    wait_halt(300);
    check("bp_resume_pc", 32'(pc), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
